universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 158 +++++++++++++++
 tb/tb_universal_shift_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left/right (logical and arithmetic),
// rotate left/right, parallel load and clear, sequenced by a small FSM that
// performs one 1-bit operation per clock for multi-bit shifts.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - operation request, sampled only in IDLE
//   mode  - operation code, captured at start
//   amt   - shift count 0..WIDTH-1, captured at start
//   din   - parallel load data, sampled at start
//   sin   - serial fill bit, sampled live on every shift edge
//   q     - registered contents
//   sout  - registered last bit shifted or rotated out
//   busy  - high while shifting
//   done  - one-cycle completion pulse
module universal_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2:0]                 mode,
    input  logic [$clog2(WIDTH)-1:0]   amt,
    input  logic [WIDTH-1:0]           din,
    input  logic                       sin,
    output logic [WIDTH-1:0]           q,
    output logic                       sout,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned AW = $clog2(WIDTH);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ASR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_LOAD = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      cnt_q,   cnt_d;
    logic [2:0]         op_q,    op_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               sout_q,  sout_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MODE_HOLD;
            data_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        sout_d  = sout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (mode)
                        MODE_LOAD: begin
                            data_d  = din;
                            state_d = ST_DONE;
                        end
                        MODE_CLR: begin
                            data_d  = '0;
                            state_d = ST_DONE;
                        end
                        MODE_HOLD: begin
                            state_d = ST_DONE;
                        end
                        default: begin
                            // Shift/rotate: a zero count completes like a hold
                            if (amt == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                op_d    = mode;
                                cnt_d   = amt;
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end

            ST_SHIFT: begin
                unique case (op_q)
                    MODE_SHL: begin
                        data_d = {data_q[WIDTH-2:0], sin};
                        sout_d = data_q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        data_d = {sin, data_q[WIDTH-1:1]};
                        sout_d = data_q[0];
                    end
                    MODE_ASR: begin
                        data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                        sout_d = data_q[0];
                    end
                    MODE_ROL: begin
                        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                        sout_d = data_q[WIDTH-1];
                    end
                    MODE_ROR: begin
                        data_d = {data_q[0], data_q[WIDTH-1:1]};
                        sout_d = data_q[0];
                    end
                    default: begin
                        data_d = data_q;
                    end
                endcase
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state
    assign q    = data_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = $clog2(WIDTH);

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       mode;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int checks;
    int failures;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .din   (din),
        .sin   (sin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                           input logic eb, input logic ed);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".sout"}, 32'(sout), 32'(es));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic issue(input logic [2:0] m, input logic [AW-1:0] a, input logic [7:0] d);
        start = 1'b1;
        mode  = m;
        amt   = a;
        din   = d;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 3'b000;
        amt   = '0;
        din   = '0;
        sin   = 1'b0;
        tick();
        tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Parallel load
        issue(3'b110, 3'd0, 8'hA5);
        chk_all("load", 8'hA5, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("load_idle", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Shift left by 3 with sin=1; scramble mode/amt/din while shifting
        sin = 1'b1;
        issue(3'b001, 3'd3, 8'h00);
        chk_all("shl_t0", 8'hA5, 1'b0, 1'b1, 1'b0);
        mode = 3'b111; amt = 3'd7; din = 8'hFF;
        tick();
        chk_all("shl_1", 8'h4B, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("shl_2", 8'h97, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("shl_3", 8'h2F, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("shl_idle", 8'h2F, 1'b1, 1'b0, 1'b0);

        // Arithmetic shift right by 2 from 0x80
        issue(3'b110, 3'd0, 8'h80);
        tick();
        issue(3'b011, 3'd2, 8'h00);
        tick();
        chk_all("asr_1", 8'hC0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("asr_2", 8'hE0, 1'b0, 1'b0, 1'b1);
        tick();

        // Rotate right by 1 from 0x01
        issue(3'b110, 3'd0, 8'h01);
        tick();
        issue(3'b101, 3'd1, 8'h00);
        chk_all("ror_t0", 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ror_1", 8'h80, 1'b1, 1'b0, 1'b1);
        tick();

        // amt=0 shift and hold both complete immediately without change
        issue(3'b001, 3'd0, 8'h00);
        chk_all("amt0", 8'h80, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("amt0_idle", 8'h80, 1'b1, 1'b0, 1'b0);
        issue(3'b000, 3'd3, 8'h00);
        chk_all("hold", 8'h80, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("hold_idle", 8'h80, 1'b1, 1'b0, 1'b0);

        // Start (clear) pulsed mid-shift is ignored
        issue(3'b110, 3'd0, 8'h3C);
        tick();
        sin = 1'b0;
        issue(3'b001, 3'd3, 8'h00);
        start = 1'b1; mode = 3'b111;
        tick();
        start = 1'b0;
        chk_all("ign_1", 8'h78, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ign_2", 8'hF0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ign_3", 8'hE0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("ign_idle", 8'hE0, 1'b1, 1'b0, 1'b0);

        // Reset mid-shift aborts; start on first non-reset edge is accepted
        issue(3'b100, 3'd5, 8'h00);
        tick();
        chk_all("rol_1", 8'hC1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        issue(3'b110, 3'd0, 8'h5A);
        chk_all("post_rst", 8'h5A, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("post_rst_idle", 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
